// File: rtl/noc_flit_pkg.sv
// Shared definitions for the NoC flit sender: flit type codes, FSM states and
// head-flit field placement.
package noc_flit_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAD = 2'b01,
        S_BODY = 2'b10
    } state_e;

    // Head payload layout: destination at the bottom, length directly above it.
    localparam int unsigned HEAD_DEST_LSB = 0;

    function automatic int unsigned head_len_lsb(input int unsigned dest_bits);
        return HEAD_DEST_LSB + dest_bits;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating link credit counter: starts full, decrements per flit sent,
// increments per credit returned, and flags credits returned beyond the maximum.
module credit_counter #(
    parameter int unsigned CREDITS = 6,
    parameter int unsigned WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             consume,
    input  logic             credit_in,
    output logic [WIDTH-1:0] count,
    output logic             has_credit,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(CREDITS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({consume, credit_in})
            2'b10:   count_d = count_q - WIDTH'(1);
            2'b01: begin
                if (count_q == MAX) err_d = 1'b1;
                else                count_d = count_q + WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= MAX;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count      = count_q;
    assign has_credit = (count_q != '0);
    assign err        = err_q;

endmodule

// File: rtl/noc_flit_sender.sv
// Credit-based link transmitter: turns a packet descriptor plus payload stream
// into head/body/tail flits written into a downstream router FIFO.
module noc_flit_sender #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEST_BITS    = 4,
    parameter int unsigned LEN_BITS     = 4,
    parameter int unsigned Q_DEPTH_BITS = 3,
    parameter int unsigned CREDITS      = (1 << Q_DEPTH_BITS) - 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ON,
    input  logic                    pkt_valid,
    input  logic [DEST_BITS-1:0]    pkt_dest,
    input  logic [LEN_BITS-1:0]     pkt_len,
    output logic                    pkt_ready,
    input  logic [DATA_WIDTH-1:0]   word_data,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [DATA_WIDTH+1:0]   flit_data,
    output logic                    flit_wrtEn,
    input  logic                    link_full,
    input  logic                    credit_in,
    output logic [Q_DEPTH_BITS:0]   credits,
    output logic                    busy,
    output logic                    credit_err
);

    import noc_flit_pkg::*;

    localparam int unsigned LEN_LSB = head_len_lsb(DEST_BITS);

    state_e                  state_q, state_d;
    logic [DEST_BITS-1:0]    dest_q, dest_d;
    logic [LEN_BITS-1:0]     len_q, len_d;
    logic [LEN_BITS-1:0]     rem_q, rem_d;
    logic [DATA_WIDTH+1:0]   last_q;
    logic [DATA_WIDTH-1:0]   head_word;
    logic [DATA_WIDTH-1:0]   fdata;
    flit_type_e              ftype;
    logic                    has_credit;
    logic                    can_send;

    credit_counter #(
        .CREDITS (CREDITS),
        .WIDTH   (Q_DEPTH_BITS + 1)
    ) u_credits (
        .clk        (clk),
        .reset      (reset),
        .consume    (flit_wrtEn),
        .credit_in  (credit_in),
        .count      (credits),
        .has_credit (has_credit),
        .err        (credit_err)
    );

    // Strobes are masked while reset is asserted so the reset cycle itself is quiet.
    assign can_send = ON & has_credit & ~link_full & ~reset;

    always_comb begin
        head_word                           = '0;
        head_word[HEAD_DEST_LSB +: DEST_BITS] = dest_q;
        head_word[LEN_LSB +: LEN_BITS]      = len_q;
    end

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        len_d      = len_q;
        rem_d      = rem_q;
        pkt_ready  = 1'b0;
        word_ready = 1'b0;
        flit_wrtEn = 1'b0;
        ftype      = FLIT_BODY;
        fdata      = '0;
        case (state_q)
            S_IDLE: begin
                if (ON && pkt_valid && !reset) begin
                    pkt_ready = 1'b1;
                    dest_d    = pkt_dest;
                    len_d     = pkt_len;
                    state_d   = S_HEAD;
                end
            end
            S_HEAD: begin
                if (can_send) begin
                    flit_wrtEn = 1'b1;
                    fdata      = head_word;
                    if (len_q == '0) begin
                        ftype   = FLIT_SINGLE;
                        state_d = S_IDLE;
                    end else begin
                        ftype   = FLIT_HEAD;
                        rem_d   = len_q;
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (can_send && word_valid) begin
                    flit_wrtEn = 1'b1;
                    word_ready = 1'b1;
                    fdata      = word_data;
                    rem_d      = rem_q - LEN_BITS'(1);
                    if (rem_q == LEN_BITS'(1)) begin
                        ftype   = FLIT_TAIL;
                        state_d = S_IDLE;
                    end else begin
                        ftype   = FLIT_BODY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign flit_data = flit_wrtEn ? {ftype, fdata} : last_q;
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            last_q  <= flit_data;
        end
    end

endmodule

// File: tb/tb_noc_flit_sender.sv
// Self-checking bench for noc_flit_sender: packet-level reference model with
// randomized payloads, flow control and credit returns.
module tb_noc_flit_sender;

    localparam int DW = 32;
    localparam int CR = 6;

    logic          clk = 1'b0;
    logic          reset, ON, pkt_valid, word_valid, link_full, credit_in;
    logic [3:0]    pkt_dest, pkt_len;
    logic [DW-1:0] word_data;
    logic          pkt_ready, word_ready, flit_wrtEn, busy, credit_err;
    logic [DW+1:0] flit_data;
    logic [3:0]    credits;

    always #5 clk = ~clk;

    noc_flit_sender #(
        .DATA_WIDTH   (32),
        .DEST_BITS    (4),
        .LEN_BITS     (4),
        .Q_DEPTH_BITS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ON         (ON),
        .pkt_valid  (pkt_valid),
        .pkt_dest   (pkt_dest),
        .pkt_len    (pkt_len),
        .pkt_ready  (pkt_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .flit_data  (flit_data),
        .flit_wrtEn (flit_wrtEn),
        .link_full  (link_full),
        .credit_in  (credit_in),
        .credits    (credits),
        .busy       (busy),
        .credit_err (credit_err)
    );

    int checks   = 0;
    int failures = 0;

    // Packet-level reference model
    int            m_credits;
    bit            m_err;
    bit            m_in_pkt;
    int            m_len, m_dest, m_sent;
    logic [DW+1:0] m_last_flit;
    logic [DW-1:0] m_words[$];
    logic [DW-1:0] m_next_words[$];

    logic          exp_wr, exp_wrdy, exp_prdy;
    logic [DW+1:0] exp_flit, act_flit;
    logic          act_wr;
    logic [42:0]   exp_vec, act_vec;

    task automatic model_reset();
        m_credits   = CR;
        m_err       = 1'b0;
        m_in_pkt    = 1'b0;
        m_sent      = 0;
        m_last_flit = '0;
        m_words.delete();
    endtask

    // One clock: drive payload word, sample mid-cycle, advance the model at the edge.
    task automatic cyc();
        if (m_in_pkt && m_sent > 0) word_data = m_words[m_sent-1];
        else                        word_data = $urandom;
        @(negedge clk);
        exp_wr   = !reset && m_in_pkt && ON && (m_credits > 0) && !link_full &&
                   (m_sent == 0 || word_valid);
        exp_wrdy = exp_wr && (m_sent > 0);
        exp_prdy = !reset && !m_in_pkt && ON && pkt_valid;
        if (!exp_wr)          exp_flit = m_last_flit;
        else if (m_sent == 0) exp_flit = {(m_len == 0) ? 2'b11 : 2'b01, 32'((m_len << 4) | m_dest)};
        else                  exp_flit = {(m_sent == m_len) ? 2'b10 : 2'b00, m_words[m_sent-1]};
        exp_vec  = {exp_wr, exp_wrdy, exp_prdy, m_in_pkt, 4'(m_credits), m_err, exp_flit};
        act_vec  = {flit_wrtEn, word_ready, pkt_ready, busy, credits, credit_err, flit_data};
        act_flit = flit_data;
        act_wr   = flit_wrtEn;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (exp_wr && !credit_in) m_credits--;
            else if (!exp_wr && credit_in) begin
                if (m_credits == CR) m_err = 1'b1;
                else                 m_credits++;
            end
            if (exp_wr) begin
                m_last_flit = exp_flit;
                m_sent++;
                if (m_sent == m_len + 1) m_in_pkt = 1'b0;
            end
            if (exp_prdy) begin
                m_in_pkt = 1'b1;
                m_len    = int'(pkt_len);
                m_dest   = int'(pkt_dest);
                m_sent   = 0;
                m_words  = m_next_words;
            end
        end
        #1;
    endtask

    task automatic set_pkt(input int dest, input int len);
        pkt_valid = 1'b1;
        pkt_dest  = 4'(dest);
        pkt_len   = 4'(len);
        m_next_words.delete();
        for (int i = 0; i < len; i++) m_next_words.push_back($urandom);
    endtask

    task automatic refill();
        credit_in = 1'b1;
        for (int i = 0; i < 8 && m_credits < CR; i++) cyc();
        credit_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ON = 1'b1; pkt_valid = 1'b0; word_valid = 1'b0;
        link_full = 1'b0; credit_in = 1'b0; pkt_dest = '0; pkt_len = '0; word_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({credits, credit_err, busy, flit_wrtEn, pkt_ready, word_ready, flit_data} !==
            {4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'd0}) begin
            failures++;
            $display("FAIL reset_values got cr=%0d err=%b busy=%b wr=%b prdy=%b wrdy=%b flit=%h want cr=6 rest 0",
                     credits, credit_err, busy, flit_wrtEn, pkt_ready, word_ready, flit_data);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (act_vec !== exp_vec) begin failures++; $display("FAIL reset_idle act=%h exp=%h", act_vec, exp_vec); end
    endtask

    task automatic test_basic();
        logic [DW+1:0] want [3];
        want[0] = {2'b01, 32'h23};
        want[1] = {2'b00, 32'hA};
        want[2] = {2'b10, 32'hB};
        set_pkt(3, 2);
        m_next_words = '{32'hA, 32'hB};
        word_valid = 1'b1;
        cyc();
        checks++;
        if (act_vec !== exp_vec) begin failures++; $display("FAIL basic_accept act=%h exp=%h", act_vec, exp_vec); end
        pkt_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec) begin failures++; $display("FAIL basic_model act=%h exp=%h", act_vec, exp_vec); end
            checks++;
            if (!(act_wr === 1'b1 && act_flit === want[i])) begin
                failures++;
                $display("FAIL basic_flit%0d got wr=%b flit=%h want wr=1 flit=%h", i, act_wr, act_flit, want[i]);
            end
        end
        checks++;
        if (credits !== 4'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_after got cr=%0d busy=%b want cr=3 busy=0", credits, busy);
        end
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        refill();
        set_pkt(5, 0);
        cyc();
        checks++;
        if (act_vec !== exp_vec) begin failures++; $display("FAIL single_accept act=%h exp=%h", act_vec, exp_vec); end
        pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec) begin failures++; $display("FAIL single_model act=%h exp=%h", act_vec, exp_vec); end
            if (act_vec[39]) busy_cnt++;
            if (act_wr) begin
                checks++;
                if (act_flit !== {2'b11, 32'h5}) begin
                    failures++; $display("FAIL single_flit got %h want %h", act_flit, {2'b11, 32'h5});
                end
            end
        end
        checks++;
        if (busy_cnt != 1) begin failures++; $display("FAIL single_busy got %0d cycles want 1", busy_cnt); end
    endtask

    task automatic test_credit_stall();
        int sent = 0;
        refill();
        set_pkt($urandom_range(0, 15), 8);
        word_valid = 1'b1;
        cyc();
        pkt_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec) begin failures++; $display("FAIL cstall_model act=%h exp=%h", act_vec, exp_vec); end
            if (act_wr) sent++;
        end
        checks++;
        if (sent != 6 || credits !== 4'd0) begin
            failures++; $display("FAIL cstall_six got sent=%0d cr=%0d want sent=6 cr=0", sent, credits);
        end
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec) begin failures++; $display("FAIL cstall_one act=%h exp=%h", act_vec, exp_vec); end
            if (act_wr) sent++;
        end
        checks++;
        if (sent != 7 || credits !== 4'd0) begin
            failures++; $display("FAIL cstall_seven got sent=%0d cr=%0d want sent=7 cr=0", sent, credits);
        end
        credit_in = 1'b1;
        for (int i = 0; i < 20 && m_in_pkt; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec) begin failures++; $display("FAIL cstall_drain act=%h exp=%h", act_vec, exp_vec); end
        end
        credit_in = 1'b0;
        checks++;
        if (m_in_pkt) begin failures++; $display("FAIL cstall_timeout got busy=1 want packet finished"); end
    endtask

    task automatic test_stall();
        logic [3:0] cr_hold;
        refill();
        set_pkt($urandom_range(0, 15), 5);
        word_valid = 1'b1;
        cyc();
        pkt_valid = 1'b0;
        repeat (2) cyc();
        cr_hold = credits;
        for (int k = 0; k < 6; k++) begin
            word_valid = (k >= 3);
            link_full  = (k >= 3);
            cyc();
            checks++;
            if (act_vec !== exp_vec || act_wr !== 1'b0 || credits !== cr_hold) begin
                failures++;
                $display("FAIL stall_%0d got wr=%b cr=%0d act=%h want wr=0 cr=%0d exp=%h",
                         k, act_wr, credits, act_vec, cr_hold, exp_vec);
            end
        end
        link_full = 1'b0;
        for (int i = 0; i < 10 && m_in_pkt; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec) begin failures++; $display("FAIL stall_resume act=%h exp=%h", act_vec, exp_vec); end
        end
        checks++;
        if (m_in_pkt) begin failures++; $display("FAIL stall_timeout got busy=1 want packet finished"); end
    endtask

    task automatic test_simul_credit();
        refill();
        set_pkt($urandom_range(0, 15), 7);
        word_valid = 1'b1;
        cyc();
        pkt_valid = 1'b0;
        credit_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec || credits !== 4'd6) begin
                failures++; $display("FAIL simul_cr got cr=%0d act=%h want cr=6 exp=%h", credits, act_vec, exp_vec);
            end
        end
        credit_in = 1'b0;
        cyc();
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        cyc();
        checks++;
        if (credits !== 4'd6 || credit_err !== 1'b1) begin
            failures++; $display("FAIL overflow got cr=%0d err=%b want cr=6 err=1", credits, credit_err);
        end
    endtask

    task automatic test_reset_mid();
        set_pkt($urandom_range(0, 15), 6);
        word_valid = 1'b1;
        cyc();
        pkt_valid = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (act_vec !== exp_vec) begin failures++; $display("FAIL rstmid_cycle act=%h exp=%h", act_vec, exp_vec); end
        reset = 1'b0;
        checks++;
        if (credits !== 4'd6 || credit_err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_state got cr=%0d err=%b busy=%b want 6 0 0", credits, credit_err, busy);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec || act_wr !== 1'b0) begin
                failures++; $display("FAIL rstmid_quiet act=%h exp=%h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_on_low();
        logic [3:0] cr0;
        set_pkt($urandom_range(0, 15), 4);
        word_valid = 1'b1;
        cyc();
        pkt_valid = 1'b0;
        repeat (2) cyc();
        cr0 = credits;
        ON = 1'b0;
        pkt_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            credit_in = (k == 1 || k == 2);
            cyc();
            checks++;
            if (act_vec !== exp_vec || act_wr !== 1'b0 || act_vec[41] !== 1'b0 || act_vec[40] !== 1'b0) begin
                failures++; $display("FAIL onlow_quiet act=%h exp=%h", act_vec, exp_vec);
            end
        end
        credit_in = 1'b0;
        pkt_valid = 1'b0;
        checks++;
        if (credits !== cr0 + 4'd2) begin
            failures++; $display("FAIL onlow_credits got %0d want %0d", credits, cr0 + 4'd2);
        end
        ON = 1'b1;
        for (int i = 0; i < 10 && m_in_pkt; i++) begin
            cyc();
            checks++;
            if (act_vec !== exp_vec) begin failures++; $display("FAIL onlow_resume act=%h exp=%h", act_vec, exp_vec); end
        end
        checks++;
        if (m_in_pkt) begin failures++; $display("FAIL onlow_timeout got busy=1 want packet finished"); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            bit accepted = 1'b0;
            set_pkt($urandom_range(0, 15), $urandom_range(0, 15));
            for (int i = 0; i < 300 && (!accepted || m_in_pkt); i++) begin
                pkt_valid  = !accepted;
                word_valid = ($urandom_range(0, 3) != 0);
                link_full  = ($urandom_range(0, 9) == 0);
                ON         = ($urandom_range(0, 9) != 0);
                credit_in  = ($urandom_range(0, 1) == 1);
                cyc();
                if (exp_prdy) accepted = 1'b1;
                checks++;
                if (act_vec !== exp_vec) begin failures++; $display("FAIL random_p%0d act=%h exp=%h", p, act_vec, exp_vec); end
            end
            checks++;
            if (!accepted || m_in_pkt) begin failures++; $display("FAIL random_timeout p%0d got unfinished want finished", p); end
        end
        pkt_valid = 1'b0; link_full = 1'b0; ON = 1'b1; credit_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_credit_stall();
        test_stall();
        test_simul_credit();
        test_reset_mid();
        test_on_low();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_flit_sender.md
Name: noc_flit_sender

Overview:
- Credit-based link transmitter that feeds a downstream router input FIFO (write side: data plus write enable).
- Takes one packet descriptor (destination, length) and a payload word stream from the local source or switch. Emits a head flit, then body flits, then a tail flit.
- Tracks downstream buffer space with a credit counter, so it never writes into a full FIFO.

Parameters:
- DATA_WIDTH, 32, payload bits per flit.
- DEST_BITS, 4, destination field width in the head flit.
- LEN_BITS, 4, payload-word count width. Packets carry 0..2^LEN_BITS-1 words.
- Q_DEPTH_BITS, 3, log2 of the downstream FIFO depth.
- CREDITS, (1<<Q_DEPTH_BITS)-2, initial and maximum credit count. Matches the downstream FIFO's early-full threshold.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ON  in  1  enable. When low, the FSM and outputs are frozen idle, but credits are still counted.
- pkt_valid  in  1  descriptor available.
- pkt_dest  in  DEST_BITS  destination id.
- pkt_len  in  LEN_BITS  number of payload words.
- pkt_ready  out  1  descriptor accepted this cycle.
- word_data  in  DATA_WIDTH  payload word.
- word_valid  in  1  payload word available.
- word_ready  out  1  payload word consumed this cycle.
- flit_data  out  DATA_WIDTH+2  {type[1:0], data}. Type codes: HEAD=01, BODY=00, TAIL=10, SINGLE=11.
- flit_wrtEn  out  1  write strobe into the downstream FIFO.
- link_full  in  1  downstream full flag, used as a hard backstop.
- credit_in  in  1  one pulse per flit the downstream FIFO has read.
- credits  out  Q_DEPTH_BITS+1  current credit count.
- busy  out  1  high whenever the FSM is not in IDLE.
- credit_err  out  1  sticky flag: credit received while the counter was already at CREDITS.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - credits=CREDITS, credit_err=0.
  - pkt_ready=0, word_ready=0, flit_wrtEn=0, flit_data=0, busy=0.
  - Reset mid-packet abandons the packet: no tail is sent, and counters reinitialise.
- Send condition: can_send = ON & (credits!=0) & ~link_full.
- FSM:
  - IDLE:
    - If ON & pkt_valid: pkt_ready=1 (combinational, same cycle), latch dest and len into regs, next state HEAD.
    - Otherwise stay in IDLE.
  - HEAD:
    - If can_send: flit_wrtEn=1, flit data = zero-extended {len, dest} with dest in bits [DEST_BITS-1:0] and len directly above.
    - If len==0: type=SINGLE, next state IDLE.
    - Otherwise: type=HEAD, remaining<=len, next state BODY.
    - Stall in HEAD while ~can_send.
  - BODY:
    - If can_send & word_valid: flit_wrtEn=1, word_ready=1 (combinational), data=word_data, remaining<=remaining-1.
    - If remaining==1: type=TAIL, next state IDLE. Otherwise type=BODY.
    - Stall while ~can_send or ~word_valid.
- Latency:
  - Descriptor accepted in cycle t; head flit earliest in t+1.
  - One flit per cycle while credits and words are available.
  - Packet of N words takes N+1 flit cycles. A new descriptor may be accepted the cycle after the tail.
- flit_data and flit_wrtEn are combinational from registered state plus inputs. flit_data holds its last value when flit_wrtEn=0.
- Credits:
  - Decrement on flit_wrtEn, increment on credit_in.
  - Both in the same cycle: unchanged.
  - credit_in with credits==CREDITS and no send: counter saturates and credit_err<=1 (sticky until reset).
  - Credits never underflow, because sends are gated by credits!=0.
- link_full=1 blocks sends even when credits>0 (covers credit/threshold mismatch).
- ON low:
  - No pkt_ready, word_ready or flit_wrtEn.
  - State and remaining are held; credit_in is still counted.
  - Resumes in place when ON returns high.
- Arithmetic: remaining is LEN_BITS wide; credits is Q_DEPTH_BITS+1 wide; no wrap.

Decomposition:
- Package noc_flit_pkg holds:
  - flit type codes: FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE.
  - FSM state encodings: S_IDLE, S_HEAD, S_BODY.
  - head-field offset constants.
- Sub-module credit_counter (parameters CREDITS, WIDTH):
  - inputs: consume, credit_in.
  - outputs: count, has_credit, err.
  - It is reused by other router output ports.

Test Plan:
- Reset then descriptor dest=3, len=2 with payload 0xA, 0xB streamed, ample credits -> flits {HEAD, 0x23}, {BODY, 0xA}, {TAIL, 0xB} in three consecutive cycles. credits 6→3, busy low after the tail.
- Descriptor len=0, dest=5 -> single flit type SINGLE, data 0x05, busy high for exactly one cycle.
- len=8 with no credit_in -> exactly 6 flits sent, then stall with credits=0. Then one credit_in pulse -> exactly one more flit; credits back to 0.
- Mid-BODY: drop word_valid for 3 cycles, and separately assert link_full with credits>0 -> no flit_wrtEn, remaining and credits unchanged, resumes with the correct next word.
- Simultaneous send and credit_in every cycle -> credits stay at 6. Extra credit_in at 6 -> credits stay at 6, credit_err=1.
- Reset asserted in BODY, and ON dropped mid-packet -> reset: IDLE, credits=6, credit_err=0. ON low: no strobes, credits still increment on credit_in, transmission resumes in place when ON returns high.
